// File: rtl/shift_issue.sv
// Operand issue stage for the 32-bit barrel shifter: 2-deep skid FIFO that
// pre-reverses right shifts and pre-inverts negative arithmetic shifts.
module shift_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_amt,
   input  logic [1:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_sel,
   output logic        out_rev,
   output logic        out_inv,
   output logic        err,
   output logic [15:0] issue_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_rd;
   logic        r_wr;
   logic [31:0] r_data [2];
   logic [4:0]  r_sel  [2];
   logic        r_rev  [2];
   logic        r_inv  [2];
   logic        r_err;
   logic [15:0] r_cnt;

   logic        w_push;
   logic        w_pop;
   logic        w_neg;
   logic [31:0] w_x;
   logic [31:0] w_xrev;
   logic [31:0] w_data;
   logic [4:0]  w_sel;
   logic        w_rev;
   logic        w_inv;
   logic        w_ill;

   assign in_ready  = (r_state != FULL) & ~rst;
   assign out_valid = (r_state != EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign out_data  = r_data[r_rd];
   assign out_sel   = r_sel[r_rd];
   assign out_rev   = r_rev[r_rd];
   assign out_inv   = r_inv[r_rd];
   assign err       = r_err;
   assign issue_cnt = r_cnt;

   // Inverting a negative SRA operand makes the zero-fill shift act as sign-fill.
   assign w_neg = (in_op == 2'b10) & in_data[31];
   assign w_x   = in_data ^ {32{w_neg}};
   assign w_ill = (in_op == 2'b11);

   always_comb begin
      w_xrev = '0;
      for (int i = 0; i < 32; i++) begin
         w_xrev[i] = w_x[31-i];
      end
   end

   always_comb begin
      w_data = in_data;
      w_sel  = in_amt;
      w_rev  = 1'b0;
      w_inv  = 1'b0;
      unique case (in_op)
         2'b00: begin
            w_data = in_data;
         end
         2'b01, 2'b10: begin
            w_data = w_xrev;
            w_rev  = 1'b1;
            w_inv  = w_neg;
         end
         2'b11: begin
            w_sel = 5'd0;
         end
         default: begin
            w_data = in_data;
         end
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         EMPTY: if (w_push) w_next = ONE;
         ONE: begin
            if (w_push & ~w_pop)
               w_next = FULL;
            else if (w_pop & ~w_push)
               w_next = EMPTY;
         end
         FULL: if (w_pop) w_next = ONE;
         default: w_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= 16'd0;
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= 32'd0;
            r_sel[i]  <= 5'd0;
            r_rev[i]  <= 1'b0;
            r_inv[i]  <= 1'b0;
         end
      end else begin
         r_state <= w_next;
         if (w_push) begin
            r_data[r_wr] <= w_data;
            r_sel[r_wr]  <= w_sel;
            r_rev[r_wr]  <= w_rev;
            r_inv[r_wr]  <= w_inv;
            r_wr         <= ~r_wr;
            if (w_ill)
               r_err <= 1'b1;
         end
         if (w_pop) begin
            r_rd  <= ~r_rd;
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue: op pre-processing, backpressure,
// illegal-op flag and mid-stream reset.
module tb_shift_issue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_sel;
   logic        out_rev;
   logic        out_inv;
   logic        err;
   logic [15:0] issue_cnt;

   int vectors;
   int miscompares;

   shift_issue dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_rev   (out_rev),
      .out_inv   (out_inv),
      .err       (err),
      .issue_cnt (issue_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d,
                        input logic [4:0] a, input logic [1:0] o);
      in_valid = v;
      in_data  = d;
      in_amt   = a;
      in_op    = o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      out_ready = 1'b0;
      step();
      step();
      vectors++;
      if (in_ready !== 1'b0) begin
         $display("FAIL reset_in_ready got=%b want=0", in_ready);
         miscompares++;
      end
      vectors++;
      if (out_valid !== 1'b0) begin
         $display("FAIL reset_out_valid got=%b want=0", out_valid);
         miscompares++;
      end
      vectors++;
      if ({out_data, out_sel, out_rev, out_inv} !== 39'd0) begin
         $display("FAIL reset_head got=%h/%b/%b/%b want=0", out_data,
                  out_sel, out_rev, out_inv);
         miscompares++;
      end
      vectors++;
      if (err !== 1'b0 || issue_cnt !== 16'd0) begin
         $display("FAIL reset_err_cnt got=%b/%0d want=0/0", err, issue_cnt);
         miscompares++;
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
         miscompares++;
      end
   endtask

   task automatic test_sll();
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_00F0, 5'd8, 2'b00);
      step();
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_00F0 ||
          out_sel !== 5'b01000 || out_rev !== 1'b0 || out_inv !== 1'b0) begin
         $display("FAIL sll got=%b/%h/%b/%b/%b want=1/000000f0/01000/0/0",
                  out_valid, out_data, out_sel, out_rev, out_inv);
         miscompares++;
      end
      step();
      vectors++;
      if (issue_cnt !== 16'd1 || out_valid !== 1'b0) begin
         $display("FAIL sll_pop got=%0d/%b want=1/0", issue_cnt, out_valid);
         miscompares++;
      end
   endtask

   task automatic test_srl_sra();
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0001, 5'd31, 2'b01);
      step();
      drive(1'b1, 32'h8000_0010, 5'd4, 2'b10);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h8000_0000 ||
          out_sel !== 5'b11111 || out_rev !== 1'b1 || out_inv !== 1'b0) begin
         $display("FAIL srl got=%b/%h/%b/%b/%b want=1/80000000/11111/1/0",
                  out_valid, out_data, out_sel, out_rev, out_inv);
         miscompares++;
      end
      step();
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'hF7FF_FFFE ||
          out_sel !== 5'b00100 || out_rev !== 1'b1 || out_inv !== 1'b1) begin
         $display("FAIL sra got=%b/%h/%b/%b/%b want=1/f7fffffe/00100/1/1",
                  out_valid, out_data, out_sel, out_rev, out_inv);
         miscompares++;
      end
      step();
      vectors++;
      if (issue_cnt !== 16'd3 || out_valid !== 1'b0) begin
         $display("FAIL sra_pop got=%0d/%b want=3/0", issue_cnt, out_valid);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_00A0, 5'd1, 2'b00);
      step();
      drive(1'b1, 32'h0000_00B1, 5'd2, 2'b00);
      step();
      drive(1'b1, 32'h0000_00C2, 5'd3, 2'b00);
      vectors++;
      if (in_ready !== 1'b0) begin
         $display("FAIL bp_full_in_ready got=%b want=0", in_ready);
         miscompares++;
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_00A0 ||
          out_sel !== 5'd1 || in_ready !== 1'b0) begin
         $display("FAIL bp_stall got=%b/%h/%0d/%b want=1/000000a0/1/0",
                  out_valid, out_data, out_sel, in_ready);
         miscompares++;
      end
      out_ready = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_00B1 ||
          out_sel !== 5'd2 || in_ready !== 1'b1) begin
         $display("FAIL bp_w1 got=%b/%h/%0d/%b want=1/000000b1/2/1",
                  out_valid, out_data, out_sel, in_ready);
         miscompares++;
      end
      step();
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_00C2 ||
          out_sel !== 5'd3) begin
         $display("FAIL bp_w2 got=%b/%h/%0d want=1/000000c2/3",
                  out_valid, out_data, out_sel);
         miscompares++;
      end
      step();
      vectors++;
      if (issue_cnt !== 16'd6 || out_valid !== 1'b0) begin
         $display("FAIL bp_cnt got=%0d/%b want=6/0", issue_cnt, out_valid);
         miscompares++;
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b0;
      drive(1'b1, 32'h1234_5678, 5'd9, 2'b11);
      step();
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 ||
          out_sel !== 5'd0 || out_rev !== 1'b0 || out_inv !== 1'b0 ||
          err !== 1'b1) begin
         $display("FAIL illegal got=%b/%h/%b/%b/%b/%b want=1/12345678/00000/0/0/1",
                  out_valid, out_data, out_sel, out_rev, out_inv, err);
         miscompares++;
      end
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_00FF, 5'd2, 2'b01);
      step();
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      vectors++;
      if (out_data !== 32'hFF00_0000 || out_rev !== 1'b1 || err !== 1'b1) begin
         $display("FAIL err_sticky got=%h/%b/%b want=ff000000/1/1",
                  out_data, out_rev, err);
         miscompares++;
      end
      step();
      vectors++;
      if (err !== 1'b1 || issue_cnt !== 16'd8) begin
         $display("FAIL err_hold got=%b/%0d want=1/8", err, issue_cnt);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0011, 5'd1, 2'b00);
      step();
      drive(1'b1, 32'h0000_0022, 5'd2, 2'b00);
      step();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         $display("FAIL mid_full got=%b/%b want=0/1", in_ready, out_valid);
         miscompares++;
      end
      rst = 1'b1;
      drive(1'b1, 32'h0000_0033, 5'd3, 2'b00);
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
         $display("FAIL mid_rst_in_ready got=%b want=0", in_ready);
         miscompares++;
      end
      step();
      vectors++;
      if (out_valid !== 1'b0 || err !== 1'b0 || issue_cnt !== 16'd0 ||
          out_data !== 32'd0) begin
         $display("FAIL mid_rst got=%b/%b/%0d/%h want=0/0/0/00000000",
                  out_valid, err, issue_cnt, out_data);
         miscompares++;
      end
      rst = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      step();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL mid_post got=%b/%b want=0/1", out_valid, in_ready);
         miscompares++;
      end
      drive(1'b1, 32'h0000_0044, 5'd4, 2'b00);
      step();
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_0044 ||
          out_sel !== 5'd4) begin
         $display("FAIL mid_repush got=%b/%h/%0d want=1/00000044/4",
                  out_valid, out_data, out_sel);
         miscompares++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      out_ready   = 1'b0;
      drive(1'b0, 32'd0, 5'd0, 2'b00);
      test_reset();
      test_sll();
      test_srl_sra();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
